// File: rtl/fft_frame_sched.sv
// -----------------------------------------------------------------------------
// fft_frame_sched
//
// Frame-level scheduler for the ping-pong bit-reversal buffer in the FFT
// datapath. It admits a programmed number of N = 2^K sample frames from the
// butterfly stream into the buffer. It tracks how many banks are full, so the
// writer never overruns an unread bank and the reader never drains a bank
// before it is complete. It also reports busy/done/progress to the CSR layer.
// The block stores no data: both handshakes pass straight through, gated by
// registered state.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   start_i, abort_i        control pulses (start in IDLE, abort in RUN/DRAIN)
//   num_frames_i            frames to process, sampled on an accepted start
//   src_valid_i/src_data_i  producer stream in; src_ready_o back-pressure
//   buf_valid_o/buf_data_o  buffer write port; buf_ready_i from the buffer
//   buf_rvalid_i/buf_rdata_i buffer read port; buf_rready_o to the buffer
//   snk_valid_o/snk_data_o  consumer stream out; snk_ready_i from the consumer
//   busy_o                  state is RUN or DRAIN
//   done_o                  one-cycle completion pulse
//   frames_out_o            frames fully delivered to the sink
//
// Optional feature, macro FFT_SCHED_PERF_EN:
//   adds saturating stall counters src_stall_cnt_o and snk_stall_cnt_o.
// -----------------------------------------------------------------------------
module fft_frame_sched #(
  parameter int K     = 10,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] num_frames_i,
  input  logic             src_valid_i,
  input  logic [DW-1:0]    src_data_i,
  output logic             src_ready_o,
  output logic             buf_valid_o,
  output logic [DW-1:0]    buf_data_o,
  input  logic             buf_ready_i,
  input  logic             buf_rvalid_i,
  input  logic [DW-1:0]    buf_rdata_i,
  output logic             buf_rready_o,
  output logic             snk_valid_o,
  output logic [DW-1:0]    snk_data_o,
  input  logic             snk_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] frames_out_o
`ifdef FFT_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0] src_stall_cnt_o,
  output logic [CNT_W-1:0] snk_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_busy;
  logic             r_done;
  logic [1:0]       r_fill;       // full banks awaiting the reader, 0..2
  logic [K-1:0]     r_wr_idx;
  logic [K-1:0]     r_rd_idx;
  logic [CNT_W-1:0] r_frames_in;
  logic [CNT_W-1:0] r_frames_out;
  logic [CNT_W-1:0] r_target;

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_wr_beat;
  logic             w_rd_beat;
  logic             w_wr_wrap;
  logic             w_rd_wrap;
  logic             w_start;
  logic             w_abort;
  logic [CNT_W-1:0] w_frames_in_nxt;
  logic [CNT_W-1:0] w_frames_out_nxt;

  // Handshake gating: combinational from registered state and same-cycle inputs.
  assign w_wr_ok = (r_state == ST_RUN) && (r_fill < 2'd2);
  assign w_rd_ok = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && (r_fill != 2'd0);

  assign buf_valid_o  = src_valid_i && w_wr_ok;
  assign src_ready_o  = buf_ready_i && w_wr_ok;
  assign buf_data_o   = src_data_i;
  assign snk_valid_o  = buf_rvalid_i && w_rd_ok;
  assign buf_rready_o = snk_ready_i && w_rd_ok;
  assign snk_data_o   = buf_rdata_i;

  assign w_wr_beat = buf_valid_o && buf_ready_i;
  assign w_rd_beat = buf_rvalid_i && buf_rready_o;
  // A bank completes on the beat that carries the last sample index.
  assign w_wr_wrap = w_wr_beat && (r_wr_idx == {K{1'b1}});
  assign w_rd_wrap = w_rd_beat && (r_rd_idx == {K{1'b1}});

  assign w_start = (r_state == ST_IDLE) && start_i;
  assign w_abort = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && abort_i;

  assign w_frames_in_nxt  = r_frames_in  + {{(CNT_W-1){1'b0}}, w_wr_wrap};
  assign w_frames_out_nxt = r_frames_out + {{(CNT_W-1){1'b0}}, w_rd_wrap};

  // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start_i) w_state_nxt = (num_frames_i == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (abort_i) w_state_nxt = ST_IDLE;
                else if (w_frames_in_nxt == r_target) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (abort_i) w_state_nxt = ST_IDLE;
                else if (w_frames_out_nxt == r_target) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fill       <= 2'd0;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_frames_in  <= '0;
      r_frames_out <= '0;
      r_target     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_start) begin
        r_target     <= num_frames_i;
        r_fill       <= 2'd0;
        r_wr_idx     <= '0;
        r_rd_idx     <= '0;
        r_frames_in  <= '0;
        r_frames_out <= '0;
      end else if (w_abort) begin
        // Progress counters keep their last value for the CSR layer to read.
        r_fill   <= 2'd0;
        r_wr_idx <= '0;
        r_rd_idx <= '0;
      end else begin
        // Beats only occur in RUN/DRAIN, so this branch is inert elsewhere.
        if (w_wr_beat) r_wr_idx <= r_wr_idx + K'(1);
        if (w_rd_beat) r_rd_idx <= r_rd_idx + K'(1);
        r_frames_in  <= w_frames_in_nxt;
        r_frames_out <= w_frames_out_nxt;
        // Simultaneous write and read wraps cancel out.
        unique case ({w_wr_wrap, w_rd_wrap})
          2'b10:   r_fill <= r_fill + 2'd1;
          2'b01:   r_fill <= r_fill - 2'd1;
          default: r_fill <= r_fill;
        endcase
      end
    end
  end

  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign frames_out_o = r_frames_out;

`ifdef FFT_SCHED_PERF_EN
  logic [CNT_W-1:0] r_src_stall;
  logic [CNT_W-1:0] r_snk_stall;
  logic             w_src_stall_ev;
  logic             w_snk_stall_ev;

  assign w_src_stall_ev = (r_state == ST_RUN) && src_valid_i && (r_fill == 2'd2);
  assign w_snk_stall_ev = buf_rvalid_i && w_rd_ok && !snk_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_src_stall <= '0;
      r_snk_stall <= '0;
    end else if (w_start) begin
      r_src_stall <= '0;
      r_snk_stall <= '0;
    end else begin
      // Saturate rather than wrap so a long stall never reads as a short one.
      if (w_src_stall_ev && (r_src_stall != {CNT_W{1'b1}})) r_src_stall <= r_src_stall + CNT_W'(1);
      if (w_snk_stall_ev && (r_snk_stall != {CNT_W{1'b1}})) r_snk_stall <= r_snk_stall + CNT_W'(1);
    end
  end

  assign src_stall_cnt_o = r_src_stall;
  assign snk_stall_cnt_o = r_snk_stall;
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_sched
//
// Self-checking bench for fft_frame_sched with K=3 (8-sample frames). The
// reference model counts write and read beats since the last start. Frames in
// and frames out are derived from those counts by integer division, and bank
// occupancy is their difference. Every cycle, the model predicts all handshake
// and status outputs from that occupancy and the randomised inputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_frame_sched;
  localparam int K     = 3;
  localparam int DW    = 32;
  localparam int CNT_W = 16;
  localparam int N     = 1 << K;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             start_i;
  logic             abort_i;
  logic [CNT_W-1:0] num_frames_i;
  logic             src_valid_i;
  logic [DW-1:0]    src_data_i;
  logic             src_ready_o;
  logic             buf_valid_o;
  logic [DW-1:0]    buf_data_o;
  logic             buf_ready_i;
  logic             buf_rvalid_i;
  logic [DW-1:0]    buf_rdata_i;
  logic             buf_rready_o;
  logic             snk_valid_o;
  logic [DW-1:0]    snk_data_o;
  logic             snk_ready_i;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] frames_out_o;

  fft_frame_sched #(.K(K), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .num_frames_i (num_frames_i),
    .src_valid_i  (src_valid_i),
    .src_data_i   (src_data_i),
    .src_ready_o  (src_ready_o),
    .buf_valid_o  (buf_valid_o),
    .buf_data_o   (buf_data_o),
    .buf_ready_i  (buf_ready_i),
    .buf_rvalid_i (buf_rvalid_i),
    .buf_rdata_i  (buf_rdata_i),
    .buf_rready_o (buf_rready_o),
    .snk_valid_o  (snk_valid_o),
    .snk_data_o   (snk_data_o),
    .snk_ready_i  (snk_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .frames_out_o (frames_out_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Percent probabilities for each randomised handshake input.
  int p_src  = 100;
  int p_bufr = 100;
  int p_rv   = 100;
  int p_snk  = 100;

  // Reference model: job activity plus beat counts since the last start.
  bit m_active;
  bit m_done;
  int m_target;
  int m_wr;
  int m_rd;
  int m_fo;

  int dut_wr_beats;
  int dut_rd_beats;
  int dut_done_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_probs(input int ps, input int pb, input int pr, input int pk);
    p_src = ps; p_bufr = pb; p_rv = pr; p_snk = pk;
  endtask

  task automatic clear_counts();
    dut_wr_beats = 0; dut_rd_beats = 0; dut_done_pulses = 0;
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_done = 1'b0; m_target = 0; m_wr = 0; m_rd = 0; m_fo = 0;
  endtask

  // One clock cycle: drive at the falling edge, check just after, advance the model.
  task automatic step(input bit st = 1'b0, input bit ab = 1'b0, input int nf = 0);
    int fi, fo_c, fill;
    bit run, wr_ok, rd_ok, e_bv, e_sr, e_rr, e_sv, wb, rb;
    @(negedge clk_i);
    start_i      = st;
    abort_i      = ab;
    num_frames_i = nf[CNT_W-1:0];
    src_valid_i  = int'($urandom_range(99)) < p_src;
    buf_ready_i  = int'($urandom_range(99)) < p_bufr;
    buf_rvalid_i = int'($urandom_range(99)) < p_rv;
    snk_ready_i  = int'($urandom_range(99)) < p_snk;
    src_data_i   = $urandom;
    buf_rdata_i  = $urandom;
    #1;
    fi    = m_wr / N;
    fo_c  = m_rd / N;
    fill  = fi - fo_c;
    run   = m_active && (fi < m_target);
    wr_ok = run && (fill < 2);
    rd_ok = m_active && (fill > 0);
    e_bv  = src_valid_i && wr_ok;
    e_sr  = buf_ready_i && wr_ok;
    e_rr  = snk_ready_i && rd_ok;
    e_sv  = buf_rvalid_i && rd_ok;
    check("src_ready",  src_ready_o,  e_sr);
    check("buf_valid",  buf_valid_o,  e_bv);
    check("buf_rready", buf_rready_o, e_rr);
    check("snk_valid",  snk_valid_o,  e_sv);
    check("busy",       busy_o,       m_active);
    check("done",       done_o,       m_done);
    check("frames_out", frames_out_o, m_fo[CNT_W-1:0]);
    check("buf_data",   buf_data_o,   src_data_i);
    check("snk_data",   snk_data_o,   buf_rdata_i);
    if (buf_valid_o && buf_ready_i) dut_wr_beats++;
    if (buf_rvalid_i && buf_rready_o) dut_rd_beats++;
    if (done_o) dut_done_pulses++;
    wb = e_bv && buf_ready_i;
    rb = e_sv && snk_ready_i;
    if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (st) begin
        m_target = nf; m_wr = 0; m_rd = 0; m_fo = 0;
        if (nf == 0) m_done = 1'b1;
        else         m_active = 1'b1;
      end
    end else if (ab) begin
      m_active = 1'b0; m_wr = 0; m_rd = 0;
    end else begin
      if (wb) m_wr++;
      if (rb) begin
        m_rd++;
        if (m_rd % N == 0) m_fo++;
      end
      if (m_rd / N >= m_target) begin
        m_active = 1'b0; m_done = 1'b1;
      end
    end
  endtask

  task automatic run_to_idle(input int budget);
    int n = 0;
    while ((m_active || m_done) && n < budget) begin
      step();
      n++;
    end
    check("run_budget", {31'b0, m_active || m_done}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_src_ready"},  src_ready_o,  0);
    check({tag, "_buf_valid"},  buf_valid_o,  0);
    check({tag, "_buf_rready"}, buf_rready_o, 0);
    check({tag, "_snk_valid"},  snk_valid_o,  0);
    check({tag, "_busy"},       busy_o,       0);
    check({tag, "_done"},       done_o,       0);
    check({tag, "_frames_out"}, frames_out_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nf;
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; num_frames_i = '0;
    src_valid_i = 1'b1; src_data_i = '0; buf_ready_i = 1'b1;
    buf_rvalid_i = 1'b1; buf_rdata_i = '0; snk_ready_i = 1'b1;
    model_reset();
    clear_counts();
    #12;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // 1: single frame at full rate.
    set_probs(100, 100, 100, 100);
    clear_counts();
    step(1'b1, 1'b0, 1);
    run_to_idle(200);
    check("t1_wr_beats", dut_wr_beats, 8);
    check("t1_rd_beats", dut_rd_beats, 8);
    check("t1_done_pulses", dut_done_pulses, 1);
    check("t1_frames_out", frames_out_o, 1);

    // 2: sink stalled until both banks are full, then released.
    set_probs(100, 100, 100, 0);
    clear_counts();
    step(1'b1, 1'b0, 3);
    repeat (30) step();
    check("t2_src_ready_full", src_ready_o, 0);
    check("t2_wr_beats_full", dut_wr_beats, 16);
    p_snk = 100;
    run_to_idle(300);
    check("t2_wr_beats", dut_wr_beats, 24);
    check("t2_rd_beats", dut_rd_beats, 24);
    check("t2_done_pulses", dut_done_pulses, 1);
    check("t2_frames_out", frames_out_o, 3);

    // 3: continuous streaming; write and read wraps coincide.
    set_probs(100, 100, 100, 100);
    clear_counts();
    step(1'b1, 1'b0, 4);
    run_to_idle(300);
    check("t3_wr_beats", dut_wr_beats, 32);
    check("t3_rd_beats", dut_rd_beats, 32);
    check("t3_done_pulses", dut_done_pulses, 1);
    check("t3_frames_out", frames_out_o, 4);

    // 4: zero frames goes straight to DONE.
    clear_counts();
    step(1'b1, 1'b0, 0);
    run_to_idle(5);
    step();
    check("t4_wr_beats", dut_wr_beats, 0);
    check("t4_rd_beats", dut_rd_beats, 0);
    check("t4_done_pulses", dut_done_pulses, 1);

    // 5: abort after five write beats, then a clean single-frame job.
    set_probs(70, 70, 70, 70);
    clear_counts();
    step(1'b1, 1'b0, 2);
    n = 0;
    while (m_wr < 5 && n < 200) begin
      step();
      n++;
    end
    check("t5_reach_5_writes", m_wr, 5);
    step(1'b0, 1'b1, 0);
    step();
    check("t5_src_ready_after_abort", src_ready_o, 0);
    check("t5_busy_after_abort", busy_o, 0);
    step();
    check("t5_no_done", dut_done_pulses, 0);
    clear_counts();
    step(1'b1, 1'b0, 1);
    run_to_idle(400);
    check("t5_done_pulses", dut_done_pulses, 1);
    check("t5_frames_out", frames_out_o, 1);

    // Random jobs under random back-pressure on every handshake.
    for (int j = 0; j < 4; j++) begin
      set_probs(int'($urandom_range(100, 40)), int'($urandom_range(100, 40)),
                int'($urandom_range(100, 40)), int'($urandom_range(100, 40)));
      nf = int'($urandom_range(3, 1));
      clear_counts();
      step(1'b1, 1'b0, nf);
      repeat (3) step(1'b1, 1'b0, 5);
      run_to_idle(1500);
      check("rand_wr_beats", dut_wr_beats, nf * N);
      check("rand_rd_beats", dut_rd_beats, nf * N);
      check("rand_done_pulses", dut_done_pulses, 1);
      check("rand_frames_out", frames_out_o, nf);
    end

    // 6: asynchronous reset in DRAIN.
    set_probs(100, 100, 100, 100);
    step(1'b1, 1'b0, 2);
    n = 0;
    while (!(m_active && (m_wr / N >= m_target)) && n < 100) begin
      step();
      n++;
    end
    check("t6_in_drain", {31'b0, m_active && (m_wr / N >= m_target)}, 1);
    check("t6_busy_before_reset", busy_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("t6_reset");
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) step();
    check("t6_frames_out", frames_out_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_frame_sched.md
Name: fft_frame_sched

Overview:
Frame-level scheduler that sequences the ping-pong bit-reversal buffer in the FFT datapath.
- Admits a programmed number of N-point frames from the butterfly stream into the buffer.
- Tracks bank occupancy so that the writer never overruns an unread bank and the reader never emits a bank that is not yet full.
- Reports busy, done and progress to the control/CSR layer.
- Sits in-line on both handshakes of the buffer: source -> sched -> buffer write port, and buffer read port -> sched -> sink.

Parameters:
K, 10, log2 of frame length N = 2^K samples.
DW, 32, sample data width; passed through unmodified.
CNT_W, 16, width of the frame-count and progress counters.

Ports:
clk_i  input  1  clock.
rst_ni  input  1  reset, asynchronous, active-low.
start_i  input  1  single-cycle start pulse; honoured only in IDLE.
abort_i  input  1  single-cycle abort pulse; honoured in RUN and DRAIN.
num_frames_i  input  CNT_W  frames to process; sampled on the accepted start.
src_valid_i  input  1  producer sample valid.
src_data_i  input  DW  producer sample.
src_ready_o  output  1  producer may transfer.
buf_valid_o  output  1  write valid to the buffer.
buf_data_o  output  DW  write data to the buffer; combinational copy of src_data_i.
buf_ready_i  input  1  buffer write ready.
buf_rvalid_i  input  1  buffer read valid.
buf_rdata_i  input  DW  buffer read data.
buf_rready_o  output  1  read ready to the buffer; the buffer read pointer advances only on buf_rvalid_i && buf_rready_o.
snk_valid_o  output  1  consumer valid.
snk_data_o  output  DW  consumer data; combinational copy of buf_rdata_i.
snk_ready_i  input  1  consumer ready.
busy_o  output  1  state is RUN or DRAIN.
done_o  output  1  one-cycle completion pulse.
frames_out_o  output  CNT_W  frames fully delivered to the sink.

Behaviour:
Reset values:
- All outputs 0; state IDLE.
- fill = 0, wr_idx = 0, rd_idx = 0, frames_in = 0, frames_out = 0.

State machine (IDLE, RUN, DRAIN, DONE):
- IDLE -> RUN on start_i with num_frames_i != 0.
  - Latches target = num_frames_i.
  - Clears wr_idx, rd_idx, fill, frames_in and frames_out.
- IDLE + start_i with num_frames_i == 0 -> DONE directly; no beats occur.
- RUN -> DRAIN in the cycle frames_in reaches target.
- DRAIN -> DONE in the cycle frames_out reaches target.
- DONE -> IDLE after exactly 1 cycle; done_o = 1 only in DONE.
- start_i outside IDLE: ignored.

Abort:
- abort_i in RUN or DRAIN -> IDLE next cycle.
- Clears fill, wr_idx and rd_idx; done_o is not pulsed.
- Holds its last value.
- The datapath must be reset alongside; the scheduler does not flush it.

Write side:
- wr_ok = (state == RUN) && (fill < 2).
- buf_valid_o = src_valid_i && wr_ok.
- src_ready_o = buf_ready_i && wr_ok.
- A write beat is buf_valid_o && buf_ready_i.
- Each write beat increments wr_idx (K bits). On wrap from N-1 to 0, frames_in increments and fill increments.

Read side:
- rd_ok = (state is RUN or DRAIN) && (fill > 0).
- snk_valid_o = buf_rvalid_i && rd_ok.
- buf_rready_o = snk_ready_i && rd_ok.
- A read beat is buf_rvalid_i && buf_rready_o.
- Each read beat increments rd_idx. On wrap, fill decrements and frames_out increments.

Boundary conditions:
- Write wrap and read wrap in the same cycle: fill unchanged; both counters update.
- fill == 2: src_ready_o = 0 even if buf_ready_i = 1.
- fill == 0: snk_valid_o = 0 even if buf_rvalid_i = 1.
- fill never exceeds 2 or goes below 0.

Timing and latency:
- All handshake outputs are combinational from registered state plus the same-cycle inputs; no data storage in this block.
- Minimum latency from the last write beat of frame f to the first sink beat of frame f: 1 cycle (fill register update).

Arithmetic:
- Counters wrap naturally at 2^K and 2^CNT_W.
- Overflow of target is not possible because target <= 2^CNT_W - 1.

Optional Feature:
Macro FFT_SCHED_PERF_EN.
- Defined: adds outputs src_stall_cnt_o and snk_stall_cnt_o, each CNT_W wide, saturating.
  - src_stall_cnt_o counts cycles with state RUN && src_valid_i && fill == 2.
  - snk_stall_cnt_o counts cycles with buf_rvalid_i && rd_ok && !snk_ready_i.
  - Both clear on an accepted start and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. K=3, start with num_frames=1, src_valid and snk_ready held 1:
   - 8 write beats, then fill = 1.
   - 8 sink beats, done_o pulses once.
   - frames_out_o = 1; busy_o drops in the DONE cycle.
2. num_frames=3, snk_ready_i held 0:
   - After 16 write beats, fill = 2 and src_ready_o = 0.
   - Raising snk_ready_i resumes writes after 8 read beats.
   - frames_out_o ends at 3.
3. Continuous streaming, num_frames=4, all readies 1:
   - A write wrap and a read wrap land in the same cycle; fill stays at 1.
   - Total 32 write beats and 32 read beats; exactly one done_o pulse.
4. num_frames=0:
   - DONE on the next cycle, done_o pulse, zero beats on both sides.
5. Abort in RUN after 5 write beats of num_frames=2:
   - IDLE next cycle; src_ready_o = 0; no done_o.
   - A following start with num_frames=1 completes normally.
6. rst_ni asserted mid-DRAIN:
   - All outputs 0 immediately, asynchronously.
   - After release: IDLE, frames_out_o = 0.
